// File: rtl/adder_tree_pkg.sv
// Shared constant functions describing the shape of the carry-save adder tree.
// Every function is a constant function so it can size localparams and
// generate loops in the tree itself.
package adder_tree_pkg;

   // Operand count after one 3:2 level: each full triple becomes two vectors,
   // the one or two leftovers pass straight through.
   function automatic int next_ops(input int ops);
      return 2 * (ops / 3) + ops % 3;
   endfunction

   // Number of 3:2 levels needed to bring n operands down to two.
   function automatic int stage_count(input int n);
      int ops;
      int cnt;
      ops = n;
      cnt = 0;
      while (ops > 2) begin
         ops = next_ops(ops);
         cnt++;
      end
      return cnt;
   endfunction

   // Operand count entering level k (levels are numbered from 1).
   function automatic int ops_at_level(input int n, input int k);
      int ops;
      ops = n;
      for (int i = 1; i < k; i++) begin
         ops = next_ops(ops);
      end
      return ops;
   endfunction

   // Number of 3:2 rows used at level k.
   function automatic int csa_at_level(input int n, input int k);
      return ops_at_level(n, k) / 3;
   endfunction

   // Number of operands that bypass the rows at level k.
   function automatic int rem_at_level(input int n, input int k);
      return ops_at_level(n, k) % 3;
   endfunction

endpackage

// File: rtl/csa_row.sv
// Single row of 3:2 compressors: turns three W-bit vectors into a sum
// vector and a carry vector already shifted into its column weight.
module csa_row #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_sum,
   output logic [W-1:0] o_carry
);

   // The carry is shifted left by one and its top bit dropped; the tree is
   // sized so that bit never carries weight in the final result.
   assign o_sum   = i_a ^ i_b ^ i_c;
   assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;

endmodule

// File: rtl/adder_tree_csa_pipe.sv
// Fully pipelined carry-save adder tree summing I_DATA_N words with a
// registered final carry-propagate add and valid/ready flow control.
// The whole pipeline stalls as one when the output is held.
module adder_tree_csa_pipe
   import adder_tree_pkg::*;
#(
   parameter int I_DATA_W = 8,
   parameter int I_DATA_N = 8,
   parameter bit SIGNED   = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [I_DATA_N*I_DATA_W-1:0]   i_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [I_DATA_W+$clog2(I_DATA_N)-1:0] o_data
);

   localparam int O_DATA_W = I_DATA_W + $clog2(I_DATA_N);
   localparam int EXT_W    = O_DATA_W - I_DATA_W;
   localparam int STAGES_N = stage_count(I_DATA_N);

   logic                advance;
   logic [O_DATA_W-1:0] ext_ops [I_DATA_N];

   // Every register level moves together; an empty output slot or a
   // consumer taking the current result lets the pipeline step.
   assign advance = ~o_valid | i_ready;
   assign o_ready = advance;

   // Widen each input word to the result width, sign- or zero-extended.
   for (genvar i = 0; i < I_DATA_N; i++) begin : g_ext
      logic [I_DATA_W-1:0] word;
      assign word = i_data[i*I_DATA_W +: I_DATA_W];
      if (SIGNED) begin : g_sext
         assign ext_ops[i] = {{EXT_W{word[I_DATA_W-1]}}, word};
      end else begin : g_zext
         assign ext_ops[i] = {{EXT_W{1'b0}}, word};
      end
   end

   // One registered 3:2 reduction level per iteration.
   for (genvar k = 1; k <= STAGES_N; k++) begin : g_lvl
      localparam int OPS_IN  = ops_at_level(I_DATA_N, k);
      localparam int N_CSA   = csa_at_level(I_DATA_N, k);
      localparam int N_REM   = rem_at_level(I_DATA_N, k);
      localparam int OPS_OUT = 2 * N_CSA + N_REM;

      logic [O_DATA_W-1:0] ops_in [OPS_IN];
      logic [O_DATA_W-1:0] ops_d  [OPS_OUT];
      logic [O_DATA_W-1:0] ops_q  [OPS_OUT];
      logic                vld_in;
      logic                vld_q;

      if (k == 1) begin : g_src_in
         assign ops_in = ext_ops;
         assign vld_in = i_valid;
      end else begin : g_src_prev
         assign ops_in = g_lvl[k-1].ops_q;
         assign vld_in = g_lvl[k-1].vld_q;
      end

      for (genvar j = 0; j < N_CSA; j++) begin : g_row
         csa_row #(.W(O_DATA_W)) u_csa_row (
            .i_a     (ops_in[3*j]),
            .i_b     (ops_in[3*j+1]),
            .i_c     (ops_in[3*j+2]),
            .o_sum   (ops_d[2*j]),
            .o_carry (ops_d[2*j+1])
         );
      end

      for (genvar r = 0; r < N_REM; r++) begin : g_pass
         assign ops_d[2*N_CSA+r] = ops_in[3*N_CSA+r];
      end

      // Capture this level's vectors and valid bit whenever the pipeline steps.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            for (int i = 0; i < OPS_OUT; i++) begin
               ops_q[i] <= '0;
            end
         end else if (advance) begin
            vld_q <= vld_in;
            ops_q <= ops_d;
         end
      end
   end

   // Final carry-propagate add of the last two vectors into the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (advance) begin
         o_valid <= g_lvl[STAGES_N].vld_q;
         o_data  <= g_lvl[STAGES_N].ops_q[0] + g_lvl[STAGES_N].ops_q[1];
      end
   end

endmodule
